// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory-side cache line responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   localparam int MEM_ADDR_W = 28;
   localparam int MEM_DATA_W = 128;

   // Fibonacci LFSR for optional response jitter: x^8+x^6+x^5+x^4+1.
   // Taps select bits 7,5,4,3 of a left-shifting register.
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line store for the responder: 2^DEPTH_LOG2 lines of DATA_W bits.
// One synchronous write port, one synchronous read port whose output
// register holds its value until the next enabled read.
module mem_line_array
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int DATA_W     = MEM_DATA_W
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [DATA_W-1:0]     rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] store_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // Store contents are not reset; they survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         store_q[wr_idx] <= wr_data;
      end
   end

   // Read register only changes on an enabled read.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = store_q[rd_idx];
      end
   end

   // Read output register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line interface. Serves one line
// read or write at a time after a fixed latency and pulses mem_ready.
// Optional feature macro: MEM_RESP_JITTER_EN adds 0..7 cycles of
// LFSR-driven extra latency to every request.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; samples op, address, write data
// BUSY  | counting down latency; both requests low aborts the transaction
// RESP  | mem_ready high for this cycle; write commits at its end
module mem_line_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int DEPTH_LOG2 = 8,
   parameter int READ_LAT   = 4,
   parameter int WRITE_LAT  = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              proto_err
);

   // Wide enough for the largest latency plus the maximum jitter of 7.
   localparam int CNT_W = $clog2(max_int(READ_LAT, WRITE_LAT) + 8);
   localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(READ_LAT);
   localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WRITE_LAT);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;

   logic [CNT_W-1:0]  lat_total;
   logic [2:0]        extra;
   logic              req_any;
   logic              op_chg;
   logic              rd_en;
   logic              wr_en;

`ifdef MEM_RESP_JITTER_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Free-running LFSR; its low three bits at sample time set the jitter.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // LFSR register, reseeded by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign extra = lfsr_q[2:0];
`else
   assign extra = 3'd0;
`endif

   assign req_any = mem_read | mem_write;
   // With a request still held, the op seen on the lines differs from the latched one.
   assign op_chg  = op_wr_q ? !mem_write : mem_write;

   // Next-state and next-output logic for the request FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      lat_total = '0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               // Write wins when both are asserted.
               op_wr_d   = mem_write;
               addr_d    = mem_addr;
               wdata_d   = mem_wdata;
               lat_total = (mem_write ? WR_LAT_C : RD_LAT_C) + CNT_W'(extra);
               cnt_d     = lat_total - ONE_C;
               if (mem_read && mem_write) begin
                  err_d = 1'b1;
               end
               state_d = (lat_total == ONE_C) ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (!req_any) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               if (op_chg || (mem_addr != addr_q)) begin
                  err_d = 1'b1;
               end
               cnt_d = cnt_q - ONE_C;
               if (cnt_q == ONE_C) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // RESP always lasts exactly one cycle, so ready follows the state.
      ready_d = (state_d == RESP);
   end

   // Reads load the array output register on the edge that enters RESP;
   // writes commit on the edge that leaves RESP.
   assign rd_en = (state_d == RESP) && !op_wr_d;
   assign wr_en = (state_q == RESP) && op_wr_q;

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   mem_line_array #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_idx  (addr_q[DEPTH_LOG2-1:0]),
      .wr_data (wdata_q),
      .rd_en   (rd_en),
      .rd_idx  (addr_d[DEPTH_LOG2-1:0]),
      .rd_data (mem_rdata)
   );

   assign mem_ready = ready_q;
   assign proto_err = err_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed cache-style transactions with a
// transaction-level reference model checked every cycle on the falling edge.
module tb_mem_line_responder;

   localparam int RL = 4;
   localparam int WL = 4;

   logic         clk;
   logic         rst_n;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         proto_err;

   int checks   = 0;
   int failures = 0;

   mem_line_responder #(
      .ADDR_W     (28),
      .DATA_W     (128),
      .DEPTH_LOG2 (8),
      .READ_LAT   (RL),
      .WRITE_LAT  (WL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_lat(input string name, input int obs, input int nom);
`ifdef MEM_RESP_JITTER_EN
      checks++;
      if (obs < nom || obs > nom + 7) begin
         failures++;
         $display("FAIL %s latency=%0d allowed=%0d..%0d", name, obs, nom, nom + 7);
      end
`else
      chk(name, 128'(obs), 128'(nom));
`endif
   endtask

   // ---------------- reference model ----------------
   logic [127:0] mem_m [256];
   bit           mem_v [256];
   bit           active, resp_now, m_wr, m_err, exp_ready, exp_rd_known;
   logic [27:0]  m_addr;
   logic [7:0]   m_idx;
   logic [127:0] m_data, exp_rdata;
   int           elapsed, need, extra_now;
   logic [7:0]   lfsr_m;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", 128'(mem_ready), 128'(0));
         chk("rst_rdata", mem_rdata, 128'(0));
         chk("rst_err", 128'(proto_err), 128'(0));
         active = 0; resp_now = 0; m_err = 0; exp_ready = 0;
         exp_rd_known = 1; exp_rdata = '0; lfsr_m = 8'hA5;
      end else begin
         chk("ready", 128'(mem_ready), 128'(exp_ready));
         if (exp_rd_known) chk("rdata", mem_rdata, exp_rdata);
         chk("proto_err", 128'(proto_err), 128'(m_err));
         // Advance the model across the coming rising edge.
`ifdef MEM_RESP_JITTER_EN
         extra_now = int'(lfsr_m[2:0]);
         lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
         extra_now = 0;
`endif
         if (resp_now) begin
            if (m_wr) begin
               mem_m[m_idx] = m_data;
               mem_v[m_idx] = 1'b1;
            end
            resp_now = 0;
            active   = 0;
         end else if (!active) begin
            if (mem_read || mem_write) begin
               active  = 1;
               m_wr    = mem_write;
               m_addr  = mem_addr;
               m_idx   = mem_addr[7:0];
               m_data  = mem_wdata;
               elapsed = 1;
               need    = (mem_write ? WL : RL) + extra_now;
               if (mem_read && mem_write) m_err = 1;
            end
         end else if (!(mem_read || mem_write)) begin
            active = 0;
         end else begin
            if (mem_addr != m_addr || mem_write != m_wr) m_err = 1;
            elapsed++;
         end
         if (active && !resp_now && elapsed == need) begin
            resp_now = 1;
            if (!m_wr) begin
               exp_rd_known = mem_v[m_idx];
               exp_rdata    = mem_m[m_idx];
            end
         end
         exp_ready = resp_now;
      end
   end

   // ---------------- cache-side driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                         input bit alt_en, input logic [27:0] alt_a,
                         output int lat, output logic [127:0] rd_at_ready, output logic [127:0] rd_after);
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = a;
      mem_wdata = d;
      lat = 0;
      do begin
         tick();
         lat++;
         if (alt_en && lat == 1) mem_addr = alt_a;
      end while (!mem_ready && lat < 40);
      if (!mem_ready) begin
         failures++;
         $display("FAIL txn_timeout addr=%h waited=%0d cycles", a, lat);
      end
      rd_at_ready = mem_rdata;
      tick();
      rd_after  = mem_rdata;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   localparam logic [127:0] D_A  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] D_B  = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;
   localparam logic [127:0] D_DB = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
   localparam logic [127:0] D_C  = 128'hA3A3_A3A3_5C5C_5C5C_0F0F_0F0F_F0F0_F0F0;
   localparam logic [127:0] D_E  = 128'h0707_0707_7070_7070_1357_9BDF_2468_ACE0;
   localparam logic [127:0] D_F  = 128'h1111_1111_2222_2222_3333_3333_4444_4444;

   initial begin
      int lat;
      int n_rand;
      logic [127:0] r0, r1;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset during a BUSY write drops it; the old line survives.
      do_txn(0, 1, 28'h05, D_A, 0, '0, lat, r0, r1);
      check_lat("t1_wr_lat", lat, WL);
      mem_write = 1'b1; mem_addr = 28'h05; mem_wdata = D_B;
      tick(); tick();
      rst_n = 1'b0; mem_write = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (3) tick();
      do_txn(1, 0, 28'h05, '0, 0, '0, lat, r0, r1);
      chk("t1_read_prior", r0, D_A);

      // Plain write then read with fixed latency; rdata held after ready.
      do_txn(0, 1, 28'h012, D_DB, 0, '0, lat, r0, r1);
      check_lat("t2_wr_lat", lat, WL);
      do_txn(1, 0, 28'h012, '0, 0, '0, lat, r0, r1);
      check_lat("t2_rd_lat", lat, RL);
      chk("t2_rdata_at_ready", r0, D_DB);
      chk("t2_rdata_held", r1, D_DB);

      // Back-to-back write then aliased read.
      do_txn(0, 1, 28'h0A3, D_C, 0, '0, lat, r0, r1);
      do_txn(1, 0, 28'h1A3, '0, 0, '0, lat, r0, r1);
      chk("t3_alias_rdata", r0, D_C);

      // Read dropped after two edges aborts; next request starts at T+3.
      mem_read = 1'b1; mem_addr = 28'h20;
      tick(); tick();
      mem_read = 1'b0;
      tick();
      do_txn(1, 0, 28'h20, '0, 0, '0, lat, r0, r1);
      check_lat("t4_after_abort_lat", lat, RL);
      chk("t4_err_clear", 128'(proto_err), 128'(0));

      // Both requests high: write served, sticky error.
      do_txn(1, 1, 28'h07, D_E, 0, '0, lat, r0, r1);
      check_lat("t5_both_lat", lat, WL);
      chk("t5_err_set", 128'(proto_err), 128'(1));
      do_txn(1, 0, 28'h07, '0, 0, '0, lat, r0, r1);
      chk("t5_written", r0, D_E);
      chk("t5_err_sticky", 128'(proto_err), 128'(1));

      // Mixed random traffic over a small index window.
`ifdef MEM_RESP_JITTER_EN
      n_rand = 100;
`else
      n_rand = 24;
`endif
      for (int i = 0; i < n_rand; i++) begin
         logic [27:0] ra;
         logic        rw;
         ra = {20'($urandom), 8'($urandom_range(0, 15))};
         rw = 1'($urandom_range(0, 1));
         do_txn(!rw, rw, ra, {$urandom, $urandom, $urandom, $urandom}, 0, '0, lat, r0, r1);
         check_lat("rand_lat", lat, rw ? WL : RL);
      end

      // Only reset clears proto_err.
      rst_n = 1'b0;
      #1;
      chk("err_cleared_by_reset", 128'(proto_err), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Address change during BUSY: latched address used, error flagged.
      do_txn(0, 1, 28'h11, D_F, 0, '0, lat, r0, r1);
      do_txn(1, 0, 28'h11, '0, 1, 28'h12, lat, r0, r1);
      chk("t7_latched_addr", r0, D_F);
      chk("t7_err_set", 128'(proto_err), 128'(1));
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
